// File: rtl/up_down_counter_if.sv
// Control/status bundle for up_down_counter.
// Optional sticky overflow signals are present only when
// UP_DOWN_COUNTER_OVF_STICKY_EN is defined.
interface up_down_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] val;
    logic             load;
    logic             en;
    logic             dir;
    logic             oneshot;
    logic [WIDTH-1:0] count;
    logic             R;
    logic             busy;
`ifdef UP_DOWN_COUNTER_OVF_STICKY_EN
    logic             ovf_clr;
    logic             ovf;
`endif

`ifdef UP_DOWN_COUNTER_OVF_STICKY_EN
    modport master (
        output val, load, en, dir, oneshot, ovf_clr,
        input  count, R, busy, ovf
    );
    modport slave (
        input  val, load, en, dir, oneshot, ovf_clr,
        output count, R, busy, ovf
    );
`else
    modport master (
        output val, load, en, dir, oneshot,
        input  count, R, busy
    );
    modport slave (
        input  val, load, en, dir, oneshot,
        output count, R, busy
    );
`endif
endinterface

// File: rtl/up_down_counter.sv
// Loadable up/down counter with wrap or one-shot mode and a registered
// terminal pulse. Defining UP_DOWN_COUNTER_OVF_STICKY_EN adds a sticky
// overflow flag (ovf) with its clear input (ovf_clr).
module up_down_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic              clk,
    input  logic              rst,
    up_down_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    // Load values above the limit are clamped so count never exceeds MAX.
    function automatic logic [WIDTH-1:0] clamp_val(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             r_q, r_nxt;
    logic             busy_q, busy_nxt;
    logic             step;
    logic             term;

    // A step is a counting edge; a terminal step is one taken at the edge of the range.
    always_comb begin
        step = bus.en && (busy_q || !bus.oneshot);
        term = !bus.load && step &&
               (bus.dir ? (count_q == MAX_V) : (count_q == ZERO_V));
    end

    // Next-state selection: load beats step; idle edges hold count and drop R.
    always_comb begin
        count_nxt = count_q;
        busy_nxt  = busy_q;
        r_nxt     = 1'b0;
        if (bus.load) begin
            count_nxt = clamp_val(bus.val);
            busy_nxt  = 1'b1;
        end else if (term) begin
            r_nxt = 1'b1;
            if (bus.oneshot)
                busy_nxt = 1'b0;
            else
                count_nxt = bus.dir ? ZERO_V : MAX_V;
        end else if (step) begin
            count_nxt = bus.dir ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    // State registers with synchronous reset overriding load and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            r_q     <= r_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.R     = r_q;
    assign bus.busy  = busy_q;

`ifdef UP_DOWN_COUNTER_OVF_STICKY_EN
    logic ovf_q;

    // Sticky overflow: a terminal step wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (term)
            ovf_q <= 1'b1;
        else if (bus.ovf_clr)
            ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule
